dcache_tag_ctrl: RTL and testbench
==================================

// Module: dcache_tag_ctrl
// PURPOSE
//  Controller directly upstream of the 16x24 dcache tag SRAM (1RW, addr/din/web registered on clk when csb0 low, dout combinational from registered addr).
//  Sequences tag lookups and tag updates for the dcache pipeline, compares tags, reports hit/dirty/victim.
//  Clears all tag entries after reset and serialises lookup, store-dirty update and line-fill writes onto the single port.
// PARAMETERS
//  ADDR_W    32  byte address width
//  SET_W      4  set index width (16 sets, matches SRAM depth)
//  OFFSET_W   6  line offset width (64 B lines)
//  TAG_W     ADDR_W-SET_W-OFFSET_W (22), localparam; SRAM word = {valid, dirty, tag} = TAG_W+2 = 24 bits
// PORTS
//  clk              in   1        clock
//  rst              in   1        asynchronous, active-high reset
//  req_valid        in   1        lookup request
//  req_ready        out  1        controller accepts request (IDLE, no fill pending)
//  req_addr         in   ADDR_W   request address; set = [OFFSET_W+:SET_W], tag = [ADDR_W-1 -: TAG_W]
//  req_write        in   1        request is a store (mark line dirty on hit)
//  resp_valid       out  1        one-cycle lookup result strobe
//  resp_hit         out  1        valid && tag match
//  resp_victim_valid out 1        stored entry valid bit
//  resp_victim_dirty out 1        stored entry dirty bit
//  resp_victim_tag  out  TAG_W    stored tag (for writeback address)
//  fill_valid       in   1        install line tag
//  fill_ready       out  1        fill accepted this cycle
//  fill_addr        in   ADDR_W   address of installed line
//  fill_dirty       in   1        dirty bit to install
//  tag_csb0         out  1        SRAM chip select, active low
//  tag_web0         out  1        SRAM write enable, active low
//  tag_addr0        out  SET_W    SRAM set index
//  tag_din0         out  TAG_W+2  SRAM write word
//  tag_dout0        in   TAG_W+2  SRAM read word
// BEHAVIOUR
//  Reset (async): state=INIT, init_idx=0; all outputs 0 except tag_csb0=1, tag_web0=1; asserting rst mid-operation aborts any lookup/update, no resp_valid.
//  States INIT, IDLE, LOOKUP, UPDATE. SRAM port driven combinationally from state; csb0=1 whenever no access.
//  INIT: each cycle write din=0 to set init_idx, init_idx++; after set 15 -> IDLE (16 cycles). req_ready=fill_ready=0.
//  IDLE: fill_valid has priority: fill_ready=1, write {1,fill_dirty,tag} to set, stay IDLE. Else req_ready=1;
//   on req_valid: read set, latch set/tag/req_write -> LOOKUP. req_ready=0 while fill_valid.
//  LOOKUP (cycle after acceptance): tag_dout0 valid; resp_valid=1, resp_* combinational from tag_dout0 and latched tag.
//   hit && req_write && !dirty -> UPDATE; otherwise -> IDLE. No SRAM access in LOOKUP.
//  UPDATE: write {1,1,latched tag} to latched set -> IDLE. Store hit on already-dirty line issues no write.
//  Lookup latency: request accepted at edge N, resp_valid in cycle N+1; throughput 1 lookup / 2 cycles (3 with dirty update).
//  SRAM write commits one edge after issue; a read issued on the cycle after a write to the same set returns the new word.
//  Miss handling (victim writeback, refill) is the requester's job; it installs via fill port.
// CONFIGURATION
//  DCACHE_TAG_STATS_EN defined: extra outputs stat_hits[31:0], stat_misses[31:0], incremented on resp_valid by hit/miss,
//   saturate at 32'hFFFF_FFFF, cleared by rst. Undefined: ports and counters absent, behaviour otherwise identical.
// STRUCTURE
//  Package dcache_tag_pkg: TAG_W/SET_W/OFFSET_W constants, tag_entry_t packed struct {valid, dirty, tag}, state_t enum.
//  Sub-module dcache_tag_stats (two saturating counters), instantiated only under DCACHE_TAG_STATS_EN. FSM, compare inline.
// TESTING
//  Reset release -> 16 consecutive writes, addr 0..15, din 24'h0, web0=0; req_ready first 1 in cycle 17.
//  Load req_addr 32'h0000_1040 (set 1, tag 4) after init -> next cycle resp_valid=1, resp_hit=0, victim_valid=0.
//  Fill 32'h0000_1040 dirty=0 -> din 24'h800004 to set 1; repeat load -> resp_hit=1, resp_victim_tag=22'h4.
//  Store hit on clean set 1 -> UPDATE writes 24'hC00004; second store hit -> resp_hit=1, dirty=1, no SRAM write.
//  fill_valid and req_valid same IDLE cycle -> fill written, req_ready=0; request accepted next cycle.
//  rst asserted during LOOKUP -> resp_valid=0 immediately, csb0=1; after release INIT restarts at set 0.

Source files
------------

// File: rtl/dcache_tag_pkg.sv
// Shared constants, tag entry layout and controller state type for the dcache tag controller.
// Optional statistics are enabled with DCACHE_TAG_STATS_EN.
package dcache_tag_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned SET_W    = 4;
  localparam int unsigned OFFSET_W = 6;
  localparam int unsigned TAG_W    = ADDR_W - SET_W - OFFSET_W;
  localparam int unsigned ENTRY_W  = TAG_W + 2;
  localparam int unsigned NUM_SETS = 1 << SET_W;

  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
  } tag_entry_t;

  typedef enum logic [1:0] {
    StInit,
    StIdle,
    StLookup,
    StUpdate
  } state_t;

  function automatic logic [SET_W-1:0] addr_set(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_W +: SET_W];
  endfunction

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

endpackage

// File: rtl/dcache_tag_ctrl_if.sv
// Request/response/fill bundle between the dcache pipeline (master) and the tag controller (slave).
// Stats outputs under DCACHE_TAG_STATS_EN are plain top-level ports, not part of this bundle.
interface dcache_tag_ctrl_if;
  import dcache_tag_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_write;

  logic              resp_valid;
  logic              resp_hit;
  logic              resp_victim_valid;
  logic              resp_victim_dirty;
  logic [TAG_W-1:0]  resp_victim_tag;

  logic              fill_valid;
  logic              fill_ready;
  logic [ADDR_W-1:0] fill_addr;
  logic              fill_dirty;

  modport master (
    output req_valid, req_addr, req_write, fill_valid, fill_addr, fill_dirty,
    input  req_ready, resp_valid, resp_hit, resp_victim_valid, resp_victim_dirty,
           resp_victim_tag, fill_ready
  );

  modport slave (
    input  req_valid, req_addr, req_write, fill_valid, fill_addr, fill_dirty,
    output req_ready, resp_valid, resp_hit, resp_victim_valid, resp_victim_dirty,
           resp_victim_tag, fill_ready
  );

endinterface

// File: rtl/dcache_tag_stats.sv
// Saturating hit/miss counters fed by the lookup response strobe.
// Instantiated by dcache_tag_ctrl only when DCACHE_TAG_STATS_EN is defined.
module dcache_tag_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_resp_valid,
  input  logic        i_resp_hit,
  output logic [31:0] o_stat_hits,
  output logic [31:0] o_stat_misses
);

  logic [31:0] r_hits;
  logic [31:0] r_misses;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hits   <= '0;
      r_misses <= '0;
    end else if (i_resp_valid) begin
      if (i_resp_hit) begin
        if (r_hits != 32'hFFFF_FFFF) r_hits <= r_hits + 32'd1;
      end else begin
        if (r_misses != 32'hFFFF_FFFF) r_misses <= r_misses + 32'd1;
      end
    end
  end

  assign o_stat_hits   = r_hits;
  assign o_stat_misses = r_misses;

endmodule

// File: rtl/dcache_tag_ctrl.sv
// Tag SRAM sequencer: clears all sets after reset, then serialises fills, lookups and dirty updates.
// Define DCACHE_TAG_STATS_EN to add saturating hit/miss counters (o_stat_hits, o_stat_misses).
module dcache_tag_ctrl
  import dcache_tag_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  dcache_tag_ctrl_if.slave   bus,
  output logic               o_tag_csb0,
  output logic               o_tag_web0,
  output logic [SET_W-1:0]   o_tag_addr0,
  output logic [ENTRY_W-1:0] o_tag_din0,
  input  logic [ENTRY_W-1:0] i_tag_dout0
`ifdef DCACHE_TAG_STATS_EN
  ,
  output logic [31:0]        o_stat_hits,
  output logic [31:0]        o_stat_misses
`endif
);

  state_t           r_state;
  logic [SET_W-1:0] r_init_idx;
  logic [SET_W-1:0] r_set;
  logic [TAG_W-1:0] r_tag;
  logic             r_write;

  tag_entry_t w_entry;
  logic       w_hit;
  logic       w_need_update;

  assign w_entry       = tag_entry_t'(i_tag_dout0);
  assign w_hit         = w_entry.valid && (w_entry.tag == r_tag);
  assign w_need_update = w_hit && r_write && !w_entry.dirty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StInit;
      r_init_idx <= '0;
      r_set      <= '0;
      r_tag      <= '0;
      r_write    <= 1'b0;
    end else begin
      unique case (r_state)
        StInit: begin
          r_init_idx <= r_init_idx + 1'b1;
          if (r_init_idx == SET_W'(NUM_SETS - 1)) r_state <= StIdle;
        end
        StIdle: begin
          // A fill in the same cycle owns the port; the request waits.
          if (!bus.fill_valid && bus.req_valid) begin
            r_set   <= addr_set(bus.req_addr);
            r_tag   <= addr_tag(bus.req_addr);
            r_write <= bus.req_write;
            r_state <= StLookup;
          end
        end
        StLookup: r_state <= w_need_update ? StUpdate : StIdle;
        StUpdate: r_state <= StIdle;
        default:  r_state <= StInit;
      endcase
    end
  end

  always_comb begin
    o_tag_csb0             = 1'b1;
    o_tag_web0             = 1'b1;
    o_tag_addr0            = '0;
    o_tag_din0             = '0;
    bus.req_ready          = 1'b0;
    bus.fill_ready         = 1'b0;
    bus.resp_valid         = 1'b0;
    bus.resp_hit           = 1'b0;
    bus.resp_victim_valid  = 1'b0;
    bus.resp_victim_dirty  = 1'b0;
    bus.resp_victim_tag    = '0;
    // Reset holds the port idle even though the state register already reads StInit.
    if (!rst) begin
      unique case (r_state)
        StInit: begin
          o_tag_csb0  = 1'b0;
          o_tag_web0  = 1'b0;
          o_tag_addr0 = r_init_idx;
        end
        StIdle: begin
          if (bus.fill_valid) begin
            bus.fill_ready = 1'b1;
            o_tag_csb0     = 1'b0;
            o_tag_web0     = 1'b0;
            o_tag_addr0    = addr_set(bus.fill_addr);
            o_tag_din0     = {1'b1, bus.fill_dirty, addr_tag(bus.fill_addr)};
          end else begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) begin
              o_tag_csb0  = 1'b0;
              o_tag_addr0 = addr_set(bus.req_addr);
            end
          end
        end
        StLookup: begin
          bus.resp_valid        = 1'b1;
          bus.resp_hit          = w_hit;
          bus.resp_victim_valid = w_entry.valid;
          bus.resp_victim_dirty = w_entry.dirty;
          bus.resp_victim_tag   = w_entry.tag;
        end
        StUpdate: begin
          o_tag_csb0  = 1'b0;
          o_tag_web0  = 1'b0;
          o_tag_addr0 = r_set;
          o_tag_din0  = {1'b1, 1'b1, r_tag};
        end
        default: ;
      endcase
    end
  end

`ifdef DCACHE_TAG_STATS_EN
  dcache_tag_stats u_stats (
    .clk           (clk),
    .rst           (rst),
    .i_resp_valid  (bus.resp_valid),
    .i_resp_hit    (bus.resp_hit),
    .o_stat_hits   (o_stat_hits),
    .o_stat_misses (o_stat_misses)
  );
`endif

endmodule

// File: tb/tb_dcache_tag_ctrl.sv
// Bench for dcache_tag_ctrl: behavioural SRAM, tag-array reference model checked every cycle,
// directed literal checks followed by randomized fills/lookups/stores and sporadic resets.
module tb_dcache_tag_ctrl;
  import dcache_tag_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dcache_tag_ctrl_if u_if();

  logic               tag_csb0;
  logic               tag_web0;
  logic [SET_W-1:0]   tag_addr0;
  logic [ENTRY_W-1:0] tag_din0;
  logic [ENTRY_W-1:0] tag_dout0;
`ifdef DCACHE_TAG_STATS_EN
  logic [31:0] stat_hits;
  logic [31:0] stat_misses;
`endif

  dcache_tag_ctrl u_dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (u_if),
    .o_tag_csb0    (tag_csb0),
    .o_tag_web0    (tag_web0),
    .o_tag_addr0   (tag_addr0),
    .o_tag_din0    (tag_din0),
    .i_tag_dout0   (tag_dout0)
`ifdef DCACHE_TAG_STATS_EN
    ,
    .o_stat_hits   (stat_hits),
    .o_stat_misses (stat_misses)
`endif
  );

  // Behavioural 1RW SRAM; contents scrambled on reset so the clear sequence matters.
  logic [ENTRY_W-1:0] sram [NUM_SETS];
  logic [SET_W-1:0]   sram_addr_q;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_SETS); i++) sram[i] <= ENTRY_W'($urandom);
      sram_addr_q <= '0;
    end else if (!tag_csb0) begin
      sram_addr_q <= tag_addr0;
      if (!tag_web0) sram[tag_addr0] <= tag_din0;
    end
  end
  assign tag_dout0 = sram[sram_addr_q];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tag array plus pending-work bookkeeping.
  bit               mv [NUM_SETS];
  bit               md [NUM_SETS];
  bit [TAG_W-1:0]   mt [NUM_SETS];
  int               init_left;
  bit               pend_resp;
  bit               pend_upd;
  bit [SET_W-1:0]   p_set;
  bit [TAG_W-1:0]   p_tag;
  bit               p_wr;
  bit               e_hit;
  int               m_idx;
  logic [31:0]      m_hits;
  logic [31:0]      m_misses;
  logic [SET_W-1:0] f_set;
  logic [TAG_W-1:0] f_tag;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_csb", 32'(tag_csb0), 32'd1);
      chk("rst_web", 32'(tag_web0), 32'd1);
      chk("rst_resp_valid", 32'(u_if.resp_valid), 32'd0);
      chk("rst_req_ready", 32'(u_if.req_ready), 32'd0);
      chk("rst_fill_ready", 32'(u_if.fill_ready), 32'd0);
`ifdef DCACHE_TAG_STATS_EN
      chk("rst_stat_hits", stat_hits, 32'd0);
      chk("rst_stat_misses", stat_misses, 32'd0);
`endif
      init_left = int'(NUM_SETS);
      pend_resp = 1'b0;
      pend_upd  = 1'b0;
      m_hits    = '0;
      m_misses  = '0;
    end else begin
`ifdef DCACHE_TAG_STATS_EN
      chk("stat_hits", stat_hits, m_hits);
      chk("stat_misses", stat_misses, m_misses);
`endif
      if (init_left > 0) begin
        m_idx = int'(NUM_SETS) - init_left;
        chk("init_csb", 32'(tag_csb0), 32'd0);
        chk("init_web", 32'(tag_web0), 32'd0);
        chk("init_addr", 32'(tag_addr0), 32'(m_idx));
        chk("init_din", 32'(tag_din0), 32'd0);
        chk("init_req_ready", 32'(u_if.req_ready), 32'd0);
        chk("init_fill_ready", 32'(u_if.fill_ready), 32'd0);
        chk("init_resp_valid", 32'(u_if.resp_valid), 32'd0);
        mv[m_idx] = 1'b0;
        md[m_idx] = 1'b0;
        mt[m_idx] = '0;
        init_left--;
      end else if (pend_resp) begin
        e_hit = mv[p_set] && (mt[p_set] == p_tag);
        chk("resp_valid", 32'(u_if.resp_valid), 32'd1);
        chk("resp_hit", 32'(u_if.resp_hit), 32'(e_hit));
        chk("resp_victim_valid", 32'(u_if.resp_victim_valid), 32'(mv[p_set]));
        chk("resp_victim_dirty", 32'(u_if.resp_victim_dirty), 32'(md[p_set]));
        chk("resp_victim_tag", 32'(u_if.resp_victim_tag), 32'(mt[p_set]));
        chk("lookup_csb", 32'(tag_csb0), 32'd1);
        chk("lookup_req_ready", 32'(u_if.req_ready), 32'd0);
        chk("lookup_fill_ready", 32'(u_if.fill_ready), 32'd0);
        if (e_hit && m_hits != 32'hFFFF_FFFF) m_hits = m_hits + 1;
        if (!e_hit && m_misses != 32'hFFFF_FFFF) m_misses = m_misses + 1;
        pend_upd  = e_hit && p_wr && !md[p_set];
        pend_resp = 1'b0;
      end else if (pend_upd) begin
        chk("upd_csb", 32'(tag_csb0), 32'd0);
        chk("upd_web", 32'(tag_web0), 32'd0);
        chk("upd_addr", 32'(tag_addr0), 32'(p_set));
        chk("upd_din", 32'(tag_din0), 32'({2'b11, p_tag}));
        chk("upd_req_ready", 32'(u_if.req_ready), 32'd0);
        chk("upd_resp_valid", 32'(u_if.resp_valid), 32'd0);
        md[p_set] = 1'b1;
        pend_upd  = 1'b0;
      end else begin
        chk("idle_resp_valid", 32'(u_if.resp_valid), 32'd0);
        if (u_if.fill_valid) begin
          f_set = u_if.fill_addr[OFFSET_W +: SET_W];
          f_tag = u_if.fill_addr[ADDR_W-1 -: TAG_W];
          chk("fill_ready", 32'(u_if.fill_ready), 32'd1);
          chk("fill_req_ready", 32'(u_if.req_ready), 32'd0);
          chk("fill_csb", 32'(tag_csb0), 32'd0);
          chk("fill_web", 32'(tag_web0), 32'd0);
          chk("fill_addr", 32'(tag_addr0), 32'(f_set));
          chk("fill_din", 32'(tag_din0), 32'({1'b1, u_if.fill_dirty, f_tag}));
          mv[f_set] = 1'b1;
          md[f_set] = u_if.fill_dirty;
          mt[f_set] = f_tag;
        end else begin
          chk("idle_fill_ready", 32'(u_if.fill_ready), 32'd0);
          chk("idle_req_ready", 32'(u_if.req_ready), 32'd1);
          if (u_if.req_valid) begin
            p_set = u_if.req_addr[OFFSET_W +: SET_W];
            p_tag = u_if.req_addr[ADDR_W-1 -: TAG_W];
            p_wr  = u_if.req_write;
            chk("read_csb", 32'(tag_csb0), 32'd0);
            chk("read_web", 32'(tag_web0), 32'd1);
            chk("read_addr", 32'(tag_addr0), 32'(p_set));
            pend_resp = 1'b1;
          end else begin
            chk("idle_csb", 32'(tag_csb0), 32'd1);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [31:0] addr, input logic wr);
    u_if.req_valid = 1'b1;
    u_if.req_addr  = addr;
    u_if.req_write = wr;
  endtask

  initial begin
    u_if.req_valid  = 1'b0;
    u_if.req_addr   = '0;
    u_if.req_write  = 1'b0;
    u_if.fill_valid = 1'b0;
    u_if.fill_addr  = '0;
    u_if.fill_dirty = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Clear sequence: 16 writes of zero to sets 0..15.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("lit_init_addr", 32'(tag_addr0), 32'(i));
      chk("lit_init_web", 32'(tag_web0), 32'd0);
      tick();
    end
    @(negedge clk);
    chk("lit_ready_after_init", 32'(u_if.req_ready), 32'd1);

    // Cold miss on set 1, tag 4.
    tick();
    send_req(32'h0000_1040, 1'b0);
    @(negedge clk);
    chk("lit_read_addr", 32'(tag_addr0), 32'd1);
    tick();
    u_if.req_valid = 1'b0;
    @(negedge clk);
    chk("lit_miss_valid", 32'(u_if.resp_valid), 32'd1);
    chk("lit_miss_hit", 32'(u_if.resp_hit), 32'd0);
    chk("lit_miss_vv", 32'(u_if.resp_victim_valid), 32'd0);

    // Install clean line, then hit it.
    tick();
    u_if.fill_valid = 1'b1;
    u_if.fill_addr  = 32'h0000_1040;
    u_if.fill_dirty = 1'b0;
    @(negedge clk);
    chk("lit_fill_din", 32'(tag_din0), 32'h0080_0004);
    chk("lit_fill_ready", 32'(u_if.fill_ready), 32'd1);
    tick();
    u_if.fill_valid = 1'b0;
    send_req(32'h0000_1040, 1'b0);
    tick();
    u_if.req_valid = 1'b0;
    @(negedge clk);
    chk("lit_hit", 32'(u_if.resp_hit), 32'd1);
    chk("lit_hit_tag", 32'(u_if.resp_victim_tag), 32'h4);

    // Store hit on clean line marks it dirty.
    tick();
    send_req(32'h0000_1040, 1'b1);
    tick();
    u_if.req_valid = 1'b0;
    u_if.req_write = 1'b0;
    @(negedge clk);
    chk("lit_store_hit", 32'(u_if.resp_hit), 32'd1);
    tick();
    @(negedge clk);
    chk("lit_upd_din", 32'(tag_din0), 32'h00C0_0004);
    chk("lit_upd_web", 32'(tag_web0), 32'd0);

    // Store hit on dirty line: no write afterwards.
    tick();
    send_req(32'h0000_1040, 1'b1);
    tick();
    u_if.req_valid = 1'b0;
    u_if.req_write = 1'b0;
    @(negedge clk);
    chk("lit_dirty_hit", 32'(u_if.resp_hit), 32'd1);
    chk("lit_dirty_bit", 32'(u_if.resp_victim_dirty), 32'd1);
    tick();
    @(negedge clk);
    chk("lit_no_write_csb", 32'(tag_csb0), 32'd1);

    // Fill and request together: fill wins, request follows, and reads the new word.
    tick();
    u_if.fill_valid = 1'b1;
    u_if.fill_addr  = 32'h0000_2080;
    u_if.fill_dirty = 1'b1;
    send_req(32'h0000_2080, 1'b0);
    @(negedge clk);
    chk("lit_collide_req_ready", 32'(u_if.req_ready), 32'd0);
    chk("lit_collide_din", 32'(tag_din0), 32'h00C0_0008);
    tick();
    u_if.fill_valid = 1'b0;
    @(negedge clk);
    chk("lit_collide_accept", 32'(u_if.req_ready), 32'd1);
    tick();
    u_if.req_valid = 1'b0;
    @(negedge clk);
    chk("lit_collide_hit", 32'(u_if.resp_hit), 32'd1);
    chk("lit_collide_dirty", 32'(u_if.resp_victim_dirty), 32'd1);

    // Reset during lookup aborts the response and restarts the clear.
    tick();
    send_req(32'h0000_1040, 1'b0);
    tick();
    u_if.req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("lit_abort_resp", 32'(u_if.resp_valid), 32'd0);
    chk("lit_abort_csb", 32'(tag_csb0), 32'd1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("lit_reinit_addr", 32'(tag_addr0), 32'd0);
    chk("lit_reinit_csb", 32'(tag_csb0), 32'd0);

    // Randomized traffic over a small set/tag pool to get frequent hits.
    for (int n = 0; n < 4000; n++) begin
      tick();
      if ($urandom_range(0, 699) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      u_if.req_valid  = ($urandom_range(0, 1) == 1);
      u_if.req_write  = ($urandom_range(0, 2) == 0);
      u_if.req_addr   = {TAG_W'($urandom_range(0, 3)), SET_W'($urandom_range(0, 3)),
                         OFFSET_W'($urandom)};
      u_if.fill_valid = ($urandom_range(0, 3) == 0);
      u_if.fill_dirty = ($urandom_range(0, 1) == 1);
      u_if.fill_addr  = {TAG_W'($urandom_range(0, 3)), SET_W'($urandom_range(0, 3)),
                         OFFSET_W'($urandom)};
    end
    tick();
    u_if.req_valid  = 1'b0;
    u_if.fill_valid = 1'b0;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
